char_glyph_drawer: RTL and testbench

Reads 12×12 glyphs from the character ROM and emits them as a stream of pixel writes. It sits between the oscilloscope text/annotation logic and the overlay framebuffer writer. Each request `{code, x, y}` drives the ROM address and captures the 144-bit glyph word. The block then scans the glyph row-major and emits one pixel per cycle under valid/ready handshaking, clipping to the active display area.

---
 rtl/char_pkg.sv | 13 +
 rtl/glyph_scan_ctr.sv | 52 +++++
 rtl/char_glyph_drawer.sv | 137 +++++++++++++
 tb/tb_char_glyph_drawer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared glyph geometry and drawer state encoding.
package char_pkg;
  localparam int GLYPH_W    = 12;
  localparam int GLYPH_H    = 12;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;
endpackage

// File: rtl/glyph_scan_ctr.sv
// Row-major cell walker: col wraps into row, last flags the final cell.
module glyph_scan_ctr #(
  parameter int COLS = 12,
  parameter int ROWS = 12,
  parameter int CW   = $clog2(COLS),
  parameter int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end, row_end;

  assign col_end = (col_q == CW'(COLS - 1));
  assign row_end = (row_q == RW'(ROWS - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (adv) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && row_end;
endmodule

// File: rtl/char_glyph_drawer.sv
// Fetches one glyph from the character ROM and streams its cells as
// clipped pixel writes over a valid/ready handshake.
module char_glyph_drawer #(
  parameter int ADDR_W     = 10,
  parameter int GLYPH_W    = 12,
  parameter int GLYPH_H    = 12,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 600,
  parameter int ROM_LAT    = 1,
  parameter int SKIP_BLANK = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_code,
  input  logic [X_W-1:0]             req_x,
  input  logic [Y_W-1:0]             req_y,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [GLYPH_W*GLYPH_H-1:0] rom_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [X_W-1:0]             pix_x,
  output logic [Y_W-1:0]             pix_y,
  output logic                       pix_on,
  output logic                       busy,
  output logic                       done
);
  import char_pkg::*;

  localparam int GB = GLYPH_W * GLYPH_H;
  localparam int CW = $clog2(GLYPH_W);
  localparam int RW = $clog2(GLYPH_H);
  localparam int WW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_t            st_q, st_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [GB-1:0]     glyph_q, glyph_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              done_q, done_d;

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              last;
  logic [X_W:0]      px;
  logic [Y_W:0]      py;
  logic              clip, emit, adv, start;

  // Extra top bit catches coordinate wrap past the counter range.
  assign px    = {1'b0, x_q} + (X_W+1)'(col);
  assign py    = {1'b0, y_q} + (Y_W+1)'(row);
  assign clip  = px[X_W] || py[Y_W] ||
                 (px >= (X_W+1)'(H_ACTIVE)) || (py >= (Y_W+1)'(V_ACTIVE));
  // Glyph register shifts left per cell, so the MSB is always the current bit.
  assign emit  = (st_q == ST_DRAW) && !clip && !((SKIP_BLANK != 0) && !glyph_q[GB-1]);
  assign adv   = (st_q == ST_DRAW) && (!emit || pix_ready);
  assign start = (st_q == ST_IDLE) && req_valid;

  glyph_scan_ctr #(.COLS(GLYPH_W), .ROWS(GLYPH_H)) u_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .adv  (adv),
    .col  (col),
    .row  (row),
    .last (last)
  );

  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    glyph_d = glyph_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    case (st_q)
      ST_IDLE: if (req_valid) begin
        addr_d = req_code;
        x_d    = req_x;
        y_d    = req_y;
        st_d   = ST_FETCH;
      end
      ST_FETCH: begin
        wcnt_d = '0;
        st_d   = ST_WAIT;
      end
      ST_WAIT: if (wcnt_q == WW'(ROM_LAT - 1)) begin
        glyph_d = rom_data;
        st_d    = ST_DRAW;
      end else begin
        wcnt_d = wcnt_q + WW'(1);
      end
      ST_DRAW: if (adv) begin
        glyph_d = {glyph_q[GB-2:0], 1'b0};
        if (last) begin
          st_d   = ST_IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      glyph_q <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      glyph_q <= glyph_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (st_q == ST_IDLE);
  assign busy      = (st_q != ST_IDLE);
  assign done      = done_q;
  assign rom_addr  = addr_q;
  assign pix_valid = emit;
  assign pix_x     = px[X_W-1:0];
  assign pix_y     = py[Y_W-1:0];
  assign pix_on    = glyph_q[GB-1];
endmodule

// File: tb/tb_char_glyph_drawer.sv
// Randomized bench: two drawers (SKIP_BLANK 0/1) against a cell-list model.
module tb_char_glyph_drawer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid [2];
  logic         req_ready [2];
  logic [9:0]   req_code  [2];
  logic [10:0]  req_x     [2];
  logic [9:0]   req_y     [2];
  logic [9:0]   rom_addr  [2];
  logic [143:0] rom_data  [2];
  logic         pix_valid [2];
  logic         pix_ready [2];
  logic [10:0]  pix_x     [2];
  logic [9:0]   pix_y     [2];
  logic         pix_on    [2];
  logic         busy      [2];
  logic         done      [2];

  logic [143:0] rom_mem [int];
  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        on;
  } pix_t;
  pix_t expq[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    char_glyph_drawer #(.SKIP_BLANK(g)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_code(req_code[g]), .req_x(req_x[g]), .req_y(req_y[g]),
      .rom_addr(rom_addr[g]), .rom_data(rom_data[g]),
      .pix_valid(pix_valid[g]), .pix_ready(pix_ready[g]),
      .pix_x(pix_x[g]), .pix_y(pix_y[g]), .pix_on(pix_on[g]),
      .busy(busy[g]), .done(done[g])
    );
  end

  // Synchronous ROM: one cycle from address to data.
  always @(posedge clk)
    for (int d = 0; d < 2; d++)
      rom_data[d] <= rom_mem.exists(int'(rom_addr[d])) ? rom_mem[int'(rom_addr[d])] : '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_req_ready", 64'(req_ready[d]), 64'(1));
    chk("rst_busy",      64'(busy[d]),      64'(0));
    chk("rst_done",      64'(done[d]),      64'(0));
    chk("rst_pix_valid", 64'(pix_valid[d]), 64'(0));
    chk("rst_pix_x",     64'(pix_x[d]),     64'(0));
    chk("rst_pix_y",     64'(pix_y[d]),     64'(0));
    chk("rst_pix_on",    64'(pix_on[d]),    64'(0));
    chk("rst_rom_addr",  64'(rom_addr[d]),  64'(0));
  endtask

  // Expected pixel list straight from the drawing rules.
  function automatic void build(input logic [143:0] g, input int x, input int y, input bit skip);
    pix_t p;
    expq.delete();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 12; c++) begin
        int  px = x + c;
        int  py = y + r;
        bit  b  = g[143 - (r*12 + c)];
        if (px < 1024 && py < 600 && !(skip && !b)) begin
          p.x = px[10:0]; p.y = py[9:0]; p.on = b;
          expq.push_back(p);
        end
      end
  endfunction

  function automatic logic [143:0] rand_glyph();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[143:0];
  endfunction

  task automatic send(input int d, input logic [9:0] code, input logic [143:0] g,
                      input int x, input int y, input bit keep);
    rom_mem[int'(code)] = g;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready[d]), 64'(1));
    req_valid[d] = 1'b1;
    req_code[d]  = code;
    req_x[d]     = x[10:0];
    req_y[d]     = y[9:0];
    @(posedge clk); #1;
    if (!keep) req_valid[d] = 1'b0;
  endtask

  task automatic watch(input int d, input logic [9:0] code, input logic [143:0] g,
                       input int x, input int y, input bit rnd, input bit timed,
                       input int abort_at, input bit hold, output int npix);
    pix_t p, prev;
    int   k = 0;
    bit   stalled = 1'b0;
    bit   fin = 1'b0;
    npix = 0;
    build(g, x, y, d == 1);
    while (!fin) begin
      @(negedge clk);
      k++;
      if (k > 4000) begin
        chk("timeout", 64'(1), 64'(0));
        break;
      end
      if (k == 1) chk("rom_addr", 64'(rom_addr[d]), 64'(code));
      p.x = pix_x[d]; p.y = pix_y[d]; p.on = pix_on[d];
      if (done[d]) begin
        chk("done_left", 64'(expq.size()), 64'(0));
        chk("done_ready", 64'(req_ready[d]), 64'(1));
        chk("done_valid", 64'(pix_valid[d]), 64'(0));
        if (timed) chk("done_cycle", 64'(k), 64'(147));
        fin = 1'b1;
      end else begin
        if (hold) chk("held_req_ready", 64'(req_ready[d]), 64'(0));
        if (pix_valid[d]) begin
          if (stalled) chk("stall_stable", 64'(p), 64'(prev));
          if (expq.size() == 0) chk("extra_pixel", 64'(1), 64'(0));
          else chk("pixel", 64'(p), 64'(expq[0]));
          if (timed && npix == 0) chk("first_cycle", 64'(k), 64'(3));
          pix_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (pix_ready[d]) begin
            if (expq.size() != 0) void'(expq.pop_front());
            npix++;
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            prev = p;
          end
        end else begin
          if (stalled) begin
            chk("valid_dropped", 64'(0), 64'(1));
            stalled = 1'b0;
          end
          pix_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
      if (abort_at >= 0 && npix == abort_at) break;
    end
    pix_ready[d] = 1'b1;
  endtask

  initial begin
    logic [143:0] g, g2;
    logic [9:0]   code;
    int           n, x, y;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; pix_ready[d] = 1'b1;
      req_code[d] = '0; req_x[d] = '0; req_y[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset(0); chk_reset(1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset(0); chk_reset(1);

    // Corner bits only: exact timing and first/last pixel on.
    g = '0; g[143] = 1'b1; g[0] = 1'b1;
    send(0, 10'h041, g, 100, 50, 1'b0);
    watch(0, 10'h041, g, 100, 50, 1'b0, 1'b1, -1, 1'b0, n);
    chk("basic_count", 64'(n), 64'(144));

    // Random glyphs/positions under random backpressure.
    for (int i = 0; i < 6; i++) begin
      g = rand_glyph(); code = 10'($urandom);
      x = (i < 3) ? $urandom_range(0, 1000) : $urandom_range(1000, 2047);
      y = (i < 3) ? $urandom_range(0, 580)  : $urandom_range(580, 1023);
      send(0, code, g, x, y, 1'b0);
      watch(0, code, g, x, y, 1'b1, 1'b0, -1, 1'b0, n);
    end

    // Clipping at the display corner and via coordinate carry.
    g = rand_glyph();
    send(0, 10'h123, g, 1020, 595, 1'b0);
    watch(0, 10'h123, g, 1020, 595, 1'b1, 1'b0, -1, 1'b0, n);
    chk("clip_corner_count", 64'(n), 64'(20));
    send(0, 10'h124, g, 2040, 10, 1'b0);
    watch(0, 10'h124, g, 2040, 10, 1'b0, 1'b0, -1, 1'b0, n);
    chk("clip_carry_count", 64'(n), 64'(0));

    // Blank skipping with a request held high throughout the draw.
    g = '0;
    while ($countones(g) < 5) g[$urandom_range(0, 143)] = 1'b1;
    g2 = rand_glyph();
    send(1, 10'h200, g, 200, 100, 1'b1);
    rom_mem[int'(10'h201)] = g2;
    req_code[1] = 10'h201; req_x[1] = 11'd300; req_y[1] = 10'd300;
    watch(1, 10'h200, g, 200, 100, 1'b1, 1'b0, -1, 1'b1, n);
    chk("skip_count", 64'(n), 64'(5));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    watch(1, 10'h201, g2, 300, 300, 1'b1, 1'b0, -1, 1'b0, n);
    chk("skip_count2", 64'(n), 64'($countones(g2)));

    // Reset in the middle of a draw, then a clean full glyph.
    g = rand_glyph();
    send(0, 10'h300, g, 10, 10, 1'b0);
    watch(0, 10'h300, g, 10, 10, 1'b0, 1'b0, 60, 1'b0, n);
    #1 rst_n = 1'b0;
    #1 chk_reset(0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 64'(done[0]), 64'(0));
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", 64'(done[0]), 64'(0));
      chk("post_rst_idle", 64'(req_ready[0]), 64'(1));
    end
    g = rand_glyph();
    send(0, 10'h301, g, 500, 300, 1'b0);
    watch(0, 10'h301, g, 500, 300, 1'b0, 1'b1, -1, 1'b0, n);
    chk("post_rst_count", 64'(n), 64'(144));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
